// File: rtl/mv_pe_if.sv
// Memory-side bundle for mv_pe: matrix (a), vector (x) and result (y) ports,
// each with a valid input so the port can sit behind a stalling cache.
interface mv_pe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] a_address0;
    logic              a_ce0;
    logic [DATA_W-1:0] a_q0;
    logic              a_valid0;
    logic [ADDR_W-1:0] x_address0;
    logic              x_ce0;
    logic [DATA_W-1:0] x_q0;
    logic              x_valid0;
    logic [ADDR_W-1:0] y_address0;
    logic              y_ce0;
    logic              y_we0;
    logic [DATA_W-1:0] y_d0;
    logic [DATA_W-1:0] y_q0;
    logic              y_valid0;

    modport master (
        output a_address0, a_ce0, x_address0, x_ce0,
        output y_address0, y_ce0, y_we0, y_d0,
        input  a_q0, a_valid0, x_q0, x_valid0, y_q0, y_valid0
    );
    modport slave (
        input  a_address0, a_ce0, x_address0, x_ce0,
        input  y_address0, y_ce0, y_we0, y_d0,
        output a_q0, a_valid0, x_q0, x_valid0, y_q0, y_valid0
    );
endinterface

// File: rtl/mv_pe.sv
// Integer matrix-vector PE: y[i] = alpha*sum_j(A[i*n+j]*x[j]) + beta*y[i].
// Define MV_SCALE_EN for alpha/beta scaling; otherwise y[i] = sum and y is write-only.
module mv_pe #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_return,
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] n,
    input  logic [DATA_W-1:0] alpha,
    input  logic [DATA_W-1:0] beta,
    mv_pe_if.master           mem,
    output logic              memory_stall
);
    typedef enum logic [2:0] {IDLE, RD_Y, WT_Y, RD_AX, MAC, WR_Y, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] m_r, n_r, i_r, j_r, row_base, acc;
    logic              ret_r;
    logic              ax_ok;

    assign ax_ok = mem.a_valid0 & mem.x_valid0;

`ifdef MV_SCALE_EN
    logic [DATA_W-1:0] alpha_r, beta_r, y_cap;
`else
    logic unused_scale;
    assign unused_scale = ^{alpha, beta, mem.y_q0, mem.y_valid0};
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ap_idle        = 1'b0;
        ap_done        = 1'b0;
        ap_ready       = 1'b0;
        memory_stall   = 1'b0;
        mem.a_ce0      = 1'b0;
        mem.x_ce0      = 1'b0;
        mem.y_ce0      = 1'b0;
        mem.y_we0      = 1'b0;
        mem.a_address0 = ADDR_W'(row_base + j_r);
        mem.x_address0 = ADDR_W'(j_r);
        mem.y_address0 = ADDR_W'(i_r);
        // Truncated two's-complement arithmetic: low bits match signed math.
`ifdef MV_SCALE_EN
        mem.y_d0       = alpha_r * acc + beta_r * y_cap;
`else
        mem.y_d0       = acc;
`endif
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    if (m == '0) state_nxt = DONE;
`ifdef MV_SCALE_EN
                    else         state_nxt = RD_Y;
`else
                    else         state_nxt = (n == '0) ? WR_Y : RD_AX;
`endif
                end
            end
            RD_Y: begin
                mem.y_ce0 = 1'b1;
                state_nxt = WT_Y;
            end
            WT_Y: begin
`ifdef MV_SCALE_EN
                // Hold ce/address of the pending read while the cache stalls.
                if (mem.y_valid0) state_nxt = (n_r == '0) ? WR_Y : RD_AX;
                else begin
                    mem.y_ce0    = 1'b1;
                    memory_stall = 1'b1;
                end
`endif
            end
            RD_AX: begin
                mem.a_ce0 = 1'b1;
                mem.x_ce0 = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                if (ax_ok) state_nxt = (j_r == n_r - 1'b1) ? WR_Y : RD_AX;
                else begin
                    mem.a_ce0    = 1'b1;
                    mem.x_ce0    = 1'b1;
                    memory_stall = 1'b1;
                end
            end
            WR_Y: begin
                mem.y_ce0 = 1'b1;
                mem.y_we0 = 1'b1;
                if (i_r == m_r - 1'b1) state_nxt = DONE;
`ifdef MV_SCALE_EN
                else                   state_nxt = RD_Y;
`else
                else                   state_nxt = (n_r == '0) ? WR_Y : RD_AX;
`endif
            end
            DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ap_return = ret_r;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_r      <= '0;
            n_r      <= '0;
            i_r      <= '0;
            j_r      <= '0;
            row_base <= '0;
            acc      <= '0;
            ret_r    <= 1'b0;
`ifdef MV_SCALE_EN
            alpha_r  <= '0;
            beta_r   <= '0;
            y_cap    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (ap_start) begin
                    m_r      <= m;
                    n_r      <= n;
                    i_r      <= '0;
                    j_r      <= '0;
                    row_base <= '0;
                    acc      <= '0;
                    ret_r    <= (m != '0);
`ifdef MV_SCALE_EN
                    alpha_r  <= alpha;
                    beta_r   <= beta;
`endif
                end
`ifdef MV_SCALE_EN
                WT_Y: if (mem.y_valid0) begin
                    y_cap <= mem.y_q0;
                    acc   <= '0;
                    j_r   <= '0;
                end
`endif
                MAC: if (ax_ok) begin
                    acc <= acc + mem.a_q0 * mem.x_q0;
                    j_r <= j_r + 1'b1;
                end
                // Row base advances by n each row, so no i*n multiplier is needed.
                WR_Y: begin
                    i_r      <= i_r + 1'b1;
                    row_base <= row_base + n_r;
                    j_r      <= '0;
                    acc      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mv_pe.sv
// Directed bench for mv_pe with a 1-cycle-latency memory model on all three ports.
module tb_mv_pe;
`ifdef MV_SCALE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready, ap_return, memory_stall;
    logic [31:0] m, n, alpha, beta;

    mv_pe_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    mv_pe #(.ADDR_W(32), .DATA_W(32)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .ap_return(ap_return), .m(m), .n(n), .alpha(alpha), .beta(beta),
        .mem(mem), .memory_stall(memory_stall)
    );

    always #5 ap_clk = ~ap_clk;

    logic [31:0] A [256];
    logic [31:0] X [16];
    logic [31:0] Y [16];

    always @(posedge ap_clk) begin
        if (mem.a_ce0) mem.a_q0 <= A[mem.a_address0[7:0]];
        if (mem.x_ce0) mem.x_q0 <= X[mem.x_address0[3:0]];
        if (mem.y_ce0 && mem.y_we0) Y[mem.y_address0[3:0]] <= mem.y_d0;
        else if (mem.y_ce0)         mem.y_q0 <= Y[mem.y_address0[3:0]];
    end

    int cyc = 0;
    always @(posedge ap_clk) cyc++;

    logic [31:0] aq[$], xq[$], wa[$], wd[$];
    int stall_cnt, ce_cnt, done_cnt, done_cyc, rdy_bad, start_cyc;
    int checks = 0;
    int errors = 0;

    always @(negedge ap_clk) begin
        if (mem.a_ce0 && !memory_stall) begin
            aq.push_back(mem.a_address0);
            xq.push_back(mem.x_address0);
        end
        if (mem.y_ce0 && mem.y_we0) begin
            wa.push_back(mem.y_address0);
            wd.push_back(mem.y_d0);
        end
        if (memory_stall) stall_cnt++;
        if (mem.a_ce0 || mem.x_ce0 || mem.y_ce0) ce_cnt++;
        if (ap_done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
            if (!ap_ready) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic start_job(input int mm, input int nn, input int aa, input int bb);
        @(negedge ap_clk);
        #1;
        aq.delete(); xq.delete(); wa.delete(); wd.delete();
        stall_cnt = 0; ce_cnt = 0; done_cnt = 0; done_cyc = 0; rdy_bad = 0;
        m = mm; n = nn; alpha = aa; beta = bb;
        start_cyc = cyc;
        ap_start = 1'b1;
        @(negedge ap_clk);
        #1 ap_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge ap_clk);
            #1 k++;
        end
        chk({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) @(negedge ap_clk);
        #1;
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_ready_with_done"}, rdy_bad, 0);
    endtask

    function automatic int row_cyc(input int nn);
        return SC ? 2 * nn + 3 : 2 * nn + 1;
    endfunction

    function automatic int exp_y(input int aa, input int bb, input int sum, input int yy);
        return SC ? aa * sum + bb * yy : sum;
    endfunction

    task automatic load_job2();
        for (int k = 0; k < 6; k++) A[k] = k + 1;
        for (int k = 0; k < 3; k++) X[k] = 1;
        Y[0] = 10; Y[1] = 10;
    endtask

    task automatic check_job2(input string tag, input int extra);
        chk({tag, "_lat"}, done_cyc - start_cyc, 1 + 2 * row_cyc(3) + extra);
        chk({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            chk({tag, "_y0_addr"}, wa[0], 0);
            chk({tag, "_y0"}, wd[0], exp_y(2, -1, 6, 10));
            chk({tag, "_y1_addr"}, wa[1], 1);
            chk({tag, "_y1"}, wd[1], exp_y(2, -1, 15, 10));
        end
        chk({tag, "_nreads"}, aq.size(), 6);
    endtask

    initial begin
        int bad_a, bad_x, bad_w;
        m = 0; n = 0; alpha = 0; beta = 0;
        mem.a_valid0 = 1'b1; mem.x_valid0 = 1'b1; mem.y_valid0 = 1'b1;

        // Reset state
        repeat (2) @(negedge ap_clk);
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_return", ap_return, 0);
        chk("rst_ce", {mem.a_ce0, mem.x_ce0, mem.y_ce0, mem.y_we0}, 0);
        chk("rst_stall", memory_stall, 0);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        chk("post_rst_idle", ap_idle, 1);
        chk("post_rst_ce", {mem.a_ce0, mem.x_ce0, mem.y_ce0}, 0);

        // 16x16, all ones
        for (int k = 0; k < 256; k++) A[k] = 1;
        for (int k = 0; k < 16; k++) begin X[k] = 1; Y[k] = 1; end
        start_job(16, 16, 1, 1);
        wait_done("big", 1000);
        chk("big_nreads", aq.size(), 256);
        bad_a = 0; bad_x = 0;
        foreach (aq[k]) begin
            if (aq[k] !== k) bad_a++;
            if (xq[k] !== (k % 16)) bad_x++;
        end
        chk("big_a_order", bad_a, 0);
        chk("big_x_order", bad_x, 0);
        chk("big_nwr", wa.size(), 16);
        bad_w = 0;
        foreach (wa[k]) if (wa[k] !== k || wd[k] !== exp_y(1, 1, 16, 1)) bad_w++;
        chk("big_writes", bad_w, 0);
        chk("big_return", ap_return, 1);
        chk("big_lat", done_cyc - start_cyc, 1 + 16 * row_cyc(16));
        chk("big_idle_after", ap_idle, 1);

        // 2x3, alpha=2, beta=-1
        load_job2();
        start_job(2, 3, 2, -1);
        wait_done("j2", 200);
        check_job2("j2", 0);
        chk("j2_stall", stall_cnt, 0);

        // m == 0
        start_job(0, 5, 1, 1);
        wait_done("m0", 50);
        chk("m0_lat", done_cyc - start_cyc, 1);
        chk("m0_no_ce", ce_cnt, 0);
        chk("m0_return", ap_return, 0);

        // n == 0
        Y[0] = 5; Y[1] = 5;
        start_job(2, 0, 1, 3);
        wait_done("n0", 50);
        chk("n0_nreads", aq.size(), 0);
        chk("n0_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("n0_y0", wd[0], exp_y(1, 3, 0, 5));
            chk("n0_y1", wd[1], exp_y(1, 3, 0, 5));
        end
        chk("n0_lat", done_cyc - start_cyc, 1 + 2 * row_cyc(0));
        chk("n0_return", ap_return, 1);

        // x_valid0 dropped for 5 cycles inside a MAC cycle
        load_job2();
        start_job(2, 3, 2, -1);
        begin
            int k = 0;
            while (!(mem.a_ce0 && !memory_stall) && k < 20) begin
                @(negedge ap_clk);
                #1 k++;
            end
            chk("stall_found_rd", (k < 20), 1);
        end
        @(posedge ap_clk);
        #1 mem.x_valid0 = 1'b0;
        repeat (5) @(posedge ap_clk);
        #1 mem.x_valid0 = 1'b1;
        wait_done("stall", 200);
        chk("stall_cycles", stall_cnt, 5);
        check_job2("stall", 5);

        // Reset in the middle of a row, then rerun
        load_job2();
        start_job(2, 3, 2, -1);
        repeat (3) @(negedge ap_clk);
        chk("mid_active", (ce_cnt > 0), 1);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_ce", {mem.a_ce0, mem.x_ce0, mem.y_ce0, mem.y_we0}, 0);
        chk("mid_rst_idle", ap_idle, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        load_job2();
        start_job(2, 3, 2, -1);
        wait_done("rerun", 200);
        check_job2("rerun", 0);
        chk("rerun_return", ap_return, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
